// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the parity receive checker:
//   - DATA_BITS_DEFAULT : default payload width of one frame
//   - state_t           : receiver FSM state encoding
//   - cnt_width()       : width of a counter that indexes DATA_BITS positions
// ---------------------------------------------------------------------------
package parity_pkg;

  localparam int DATA_BITS_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
  } state_t;

  // A one-bit payload still needs a one-bit counter ($clog2(1) is 0).
  function automatic int cnt_width(input int bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/parity4.sv
// ---------------------------------------------------------------------------
// parity4
// Combinational even-parity generator: XOR reduction of a 4-bit word.
// Ports:
//   i_data   [3:0]  word to reduce
//   o_parity        XOR of all four bits (1 when the word has an odd number
//                   of ones)
// ---------------------------------------------------------------------------
module parity4 (
  input  logic [3:0] i_data,
  output logic       o_parity
);

  assign o_parity = ^i_data;

endmodule

// File: rtl/parity_rx_checker.sv
// ---------------------------------------------------------------------------
// parity_rx_checker
// Receives serial frames of the form
//   start(0) | DATA_BITS data bits, LSB first | even parity | stop(1)
// sampling rx_in only on cycles where bit_en is high. At the stop bit the
// payload is published with a one-cycle data_valid pulse, together with a
// parity error flag and a framing error flag. A low stop bit means the line
// is in a break condition; the receiver then waits for the line to return
// high before it will accept another start bit.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset, wins over bit_en
//   bit_en      bit strobe; rx_in is only looked at when this is high
//   rx_in       serial line, idle high
//   data_out    last received payload, bit 0 = first data bit on the line
//   data_valid  one-cycle pulse after the edge that samples the stop bit
//   parity_err  received parity differs from XOR of the payload
//   frame_err   stop bit was sampled low
//   busy        high in every state except IDLE
// data_out, parity_err and frame_err hold until the next frame completes.
// The parity generator is a fixed 4-input XOR, so DATA_BITS must stay at its
// default of 4.
// ---------------------------------------------------------------------------
module parity_rx_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_rx;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_busy;

  logic                 w_par_calc;

  // Parity is taken over the fully assembled shift register; by the time the
  // stop bit is sampled every payload position has been written this frame.
  parity4 u_parity4 (
    .i_data   (r_shift),
    .o_parity (w_par_calc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_rx     <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // data_valid is a single-cycle pulse; everything else only moves on a
      // strobe.
      r_data_valid <= 1'b0;
      if (bit_en) begin
        case (r_state)
          ST_IDLE: begin
            if (!rx_in) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
              r_busy    <= 1'b1;
            end
          end
          ST_DATA: begin
            r_shift[r_bit_cnt] <= rx_in;
            r_bit_cnt          <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_par_rx <= rx_in;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            r_data_out   <= r_shift;
            r_data_valid <= 1'b1;
            r_parity_err <= r_par_rx ^ w_par_calc;
            r_frame_err  <= ~rx_in;
            if (rx_in) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              // Line held low through the stop slot: treat as a break and
              // refuse to see the low level as a new start bit.
              r_state <= ST_BREAK;
              r_busy  <= 1'b1;
            end
          end
          ST_BREAK: begin
            if (rx_in) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule
